// File: rtl/bp_me_cfg_responder.sv
// bp_me_cfg_responder: per-tile configuration endpoint for the uncached
// config command stream. Each accepted uc_wr/uc_rd either updates or reads a
// config register, or drives the CCE ucode RAM port. Exactly one response is
// returned per accepted command, including error cases.
//
// Optional build macro: BP_ME_CFG_TILE_CHECK_EN. When defined, a command only
// hits this endpoint if its tile field matches tile_id_i.
//
// Header layout, MSB to LSB: payload | size | addr | subop | msg_type
// Local address layout, MSB to LSB: nonlocal | tile | dev | dev_addr
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | ready for a command; latch header, data and decode on accept
// EXEC       | apply the command; ucode strobe is high in this cycle
// UC_RD_WAIT | capture ucode read data returned one cycle after the strobe
// RESP       | hold the response until it is consumed
module bp_me_cfg_responder
  #(parameter int paddr_width_p         = 40
   ,parameter int dev_addr_width_gp     = 20
   ,parameter int dword_width_gp        = 64
   ,parameter int tile_id_width_p       = 7
   ,parameter int payload_width_p       = 16
   ,parameter int lce_mode_width_p      = 3
   ,parameter int cce_mode_width_p      = 1
   ,parameter int inst_ram_els_p        = 256
   ,parameter int inst_ram_addr_width_p = 8
   ,parameter int inst_width_p          = 64
   ,localparam int msg_type_width_lp    = 4
   ,localparam int subop_width_lp       = 4
   ,localparam int size_width_lp        = 3
   ,localparam int mem_header_width_lp  = payload_width_p + size_width_lp + paddr_width_p
                                          + subop_width_lp + msg_type_width_lp
   )
  (input  logic                             clk_i
  ,input  logic                             reset_n_i
  ,input  logic [tile_id_width_p-1:0]       tile_id_i

  ,input  logic [mem_header_width_lp-1:0]   io_cmd_header_i
  ,input  logic [dword_width_gp-1:0]        io_cmd_data_i
  ,input  logic                             io_cmd_v_i
  ,output logic                             io_cmd_ready_and_o
  ,input  logic                             io_cmd_last_i

  ,output logic [mem_header_width_lp-1:0]   io_resp_header_o
  ,output logic [dword_width_gp-1:0]        io_resp_data_o
  ,output logic                             io_resp_v_o
  ,input  logic                             io_resp_yumi_i
  ,output logic                             io_resp_last_o

  ,output logic                             freeze_o
  ,output logic [lce_mode_width_p-1:0]      icache_mode_o
  ,output logic [lce_mode_width_p-1:0]      dcache_mode_o
  ,output logic [cce_mode_width_p-1:0]      cce_mode_o
  ,output logic [dword_width_gp-1:0]        hio_mask_o

  ,output logic                             ucode_v_o
  ,output logic                             ucode_w_o
  ,output logic [inst_ram_addr_width_p-1:0] ucode_addr_o
  ,output logic [inst_width_p-1:0]          ucode_data_o
  ,input  logic [inst_width_p-1:0]          ucode_data_i

  ,output logic                             err_o
  );

  localparam int dev_width_lp      = 4;
  localparam int nonlocal_width_lp = paddr_width_p - tile_id_width_p - dev_width_lp - dev_addr_width_gp;
  localparam int addr_lsb_lp       = msg_type_width_lp + subop_width_lp;

  localparam logic [msg_type_width_lp-1:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [msg_type_width_lp-1:0] e_bedrock_mem_uc_wr = 4'd3;

  localparam logic [dev_width_lp-1:0] cfg_dev_gp = 4'd2;

  localparam logic [dev_addr_width_gp-1:0] cfg_reg_freeze_gp      = 'h0_0008;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_icache_mode_gp = 'h0_0010;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_dcache_mode_gp = 'h0_0018;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_cce_mode_gp    = 'h0_0020;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_hio_mask_gp    = 'h0_0028;

  localparam logic [31:0] cfg_mem_cce_ucode_base_gp = 32'h0000_8000;
  localparam logic [31:0] ucode_lim_lp = cfg_mem_cce_ucode_base_gp + 32'(8 * inst_ram_els_p);

  localparam logic [lce_mode_width_p-1:0] e_lce_mode_uncached = '0;
  localparam logic [cce_mode_width_p-1:0] e_cce_mode_uncached = '0;

  typedef struct packed {
    logic [nonlocal_width_lp-1:0] nonlocal;
    logic [tile_id_width_p-1:0]   tile;
    logic [dev_width_lp-1:0]      dev;
    logic [dev_addr_width_gp-1:0] addr;
  } local_addr_s;

  typedef enum logic [1:0] {e_idle, e_exec, e_uc_rd_wait, e_resp} state_e;
  typedef enum logic [2:0] {e_op_err, e_op_reg_wr, e_op_reg_rd, e_op_uc_wr, e_op_uc_rd} op_e;
  typedef enum logic [2:0] {e_sel_freeze, e_sel_icache, e_sel_dcache, e_sel_cce, e_sel_hio} sel_e;

  state_e                     state_r;
  op_e                        op_r, dec_op;
  sel_e                       sel_r, dec_sel;
  logic [mem_header_width_lp-1:0] hdr_r;
  logic [dword_width_gp-1:0]  data_r;
  logic [dword_width_gp-1:0]  reg_rdata;

  logic [msg_type_width_lp-1:0] cmd_msg_li;
  local_addr_s                cmd_addr_li;
  logic [31:0]                cmd_off_li, ucode_off_li;
  logic                       cmd_is_wr, cmd_is_rd, tile_hit_li, cmd_hit_li;
  logic                       reg_hit_li, uc_hit_li;
  logic [inst_ram_addr_width_p-1:0] dec_idx;
  logic                       unused_bits;

  assign cmd_msg_li   = io_cmd_header_i[msg_type_width_lp-1:0];
  assign cmd_addr_li  = io_cmd_header_i[addr_lsb_lp+:paddr_width_p];
  assign cmd_off_li   = 32'(cmd_addr_li.addr);
  assign ucode_off_li = cmd_off_li - cfg_mem_cce_ucode_base_gp;
  assign dec_idx      = ucode_off_li[inst_ram_addr_width_p+2:3];
  assign cmd_is_wr    = (cmd_msg_li == e_bedrock_mem_uc_wr);
  assign cmd_is_rd    = (cmd_msg_li == e_bedrock_mem_uc_rd);
  assign uc_hit_li    = (cmd_off_li >= cfg_mem_cce_ucode_base_gp) && (cmd_off_li < ucode_lim_lp);

`ifdef BP_ME_CFG_TILE_CHECK_EN
  assign tile_hit_li = (cmd_addr_li.tile == tile_id_i);
  assign unused_bits = ^{io_cmd_last_i, ucode_off_li[2:0], ucode_off_li[31:inst_ram_addr_width_p+3]};
`else
  // Tile field is deliberately ignored in this build.
  assign tile_hit_li = 1'b1;
  assign unused_bits = ^{io_cmd_last_i, ucode_off_li[2:0], ucode_off_li[31:inst_ram_addr_width_p+3],
                         cmd_addr_li.tile, tile_id_i};
`endif

  // A hit needs a uc message to the cfg device of this (local) tile.
  assign cmd_hit_li = (cmd_is_wr | cmd_is_rd) && (cmd_addr_li.dev == cfg_dev_gp)
                      && (cmd_addr_li.nonlocal == '0) && tile_hit_li;

  assign io_resp_header_o = hdr_r;
  assign io_resp_last_o   = 1'b1;

  // Decode the incoming command into an operation and register select.
  always_comb begin
    dec_op     = e_op_err;
    dec_sel    = e_sel_freeze;
    reg_hit_li = 1'b1;
    case (cmd_addr_li.addr)
      cfg_reg_freeze_gp:      dec_sel = e_sel_freeze;
      cfg_reg_icache_mode_gp: dec_sel = e_sel_icache;
      cfg_reg_dcache_mode_gp: dec_sel = e_sel_dcache;
      cfg_reg_cce_mode_gp:    dec_sel = e_sel_cce;
      cfg_reg_hio_mask_gp:    dec_sel = e_sel_hio;
      default:                reg_hit_li = 1'b0;
    endcase
    if (cmd_hit_li) begin
      if (reg_hit_li)
        dec_op = cmd_is_wr ? e_op_reg_wr : e_op_reg_rd;
      else if (uc_hit_li)
        dec_op = cmd_is_wr ? e_op_uc_wr : e_op_uc_rd;
    end
  end

  // Current value of the selected config register, zero-extended.
  always_comb begin
    reg_rdata = '0;
    case (sel_r)
      e_sel_freeze: reg_rdata = dword_width_gp'(freeze_o);
      e_sel_icache: reg_rdata = dword_width_gp'(icache_mode_o);
      e_sel_dcache: reg_rdata = dword_width_gp'(dcache_mode_o);
      e_sel_cce:    reg_rdata = dword_width_gp'(cce_mode_o);
      e_sel_hio:    reg_rdata = hio_mask_o;
      default:      reg_rdata = '0;
    endcase
  end

  // Command FSM with registered handshake, config and ucode outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r            <= e_idle;
      op_r               <= e_op_err;
      sel_r              <= e_sel_freeze;
      hdr_r              <= '0;
      data_r             <= '0;
      io_cmd_ready_and_o <= 1'b0;
      io_resp_v_o        <= 1'b0;
      io_resp_data_o     <= '0;
      ucode_v_o          <= 1'b0;
      ucode_w_o          <= 1'b0;
      ucode_addr_o       <= '0;
      ucode_data_o       <= '0;
      freeze_o           <= 1'b1;
      icache_mode_o      <= e_lce_mode_uncached;
      dcache_mode_o      <= e_lce_mode_uncached;
      cce_mode_o         <= e_cce_mode_uncached;
      hio_mask_o         <= '0;
      err_o              <= 1'b0;
    end else begin
      ucode_v_o <= 1'b0;
      case (state_r)
        e_idle: begin
          if (io_cmd_v_i & io_cmd_ready_and_o) begin
            hdr_r              <= io_cmd_header_i;
            data_r             <= io_cmd_data_i;
            op_r               <= dec_op;
            sel_r              <= dec_sel;
            io_cmd_ready_and_o <= 1'b0;
            // The strobe is registered here so it is high exactly in EXEC.
            ucode_v_o          <= (dec_op == e_op_uc_wr) || (dec_op == e_op_uc_rd);
            ucode_w_o          <= (dec_op == e_op_uc_wr);
            ucode_addr_o       <= dec_idx;
            ucode_data_o       <= io_cmd_data_i[inst_width_p-1:0];
            state_r            <= e_exec;
          end else begin
            io_cmd_ready_and_o <= 1'b1;
          end
        end
        e_exec: begin
          io_resp_data_o <= '0;
          case (op_r)
            e_op_reg_wr: begin
              case (sel_r)
                e_sel_freeze: freeze_o      <= data_r[0];
                e_sel_icache: icache_mode_o <= data_r[lce_mode_width_p-1:0];
                e_sel_dcache: dcache_mode_o <= data_r[lce_mode_width_p-1:0];
                e_sel_cce:    cce_mode_o    <= data_r[cce_mode_width_p-1:0];
                e_sel_hio:    hio_mask_o    <= data_r;
                default: ;
              endcase
              io_resp_v_o <= 1'b1;
              state_r     <= e_resp;
            end
            e_op_reg_rd: begin
              io_resp_data_o <= reg_rdata;
              io_resp_v_o    <= 1'b1;
              state_r        <= e_resp;
            end
            e_op_uc_wr: begin
              io_resp_v_o <= 1'b1;
              state_r     <= e_resp;
            end
            e_op_uc_rd: begin
              state_r <= e_uc_rd_wait;
            end
            default: begin
              err_o       <= 1'b1;
              io_resp_v_o <= 1'b1;
              state_r     <= e_resp;
            end
          endcase
        end
        e_uc_rd_wait: begin
          io_resp_data_o <= dword_width_gp'(ucode_data_i);
          io_resp_v_o    <= 1'b1;
          state_r        <= e_resp;
        end
        e_resp: begin
          if (io_resp_yumi_i) begin
            io_resp_v_o        <= 1'b0;
            io_cmd_ready_and_o <= 1'b1;
            state_r            <= e_idle;
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_cfg_responder.sv
// Randomized bench for bp_me_cfg_responder against a behavioural model of
// the config register map and ucode store.
`timescale 1ns/1ps
module tb_bp_me_cfg_responder;

  localparam int ELS = 256;
  localparam int IAW = 8;
  localparam int IW  = 64;
  localparam int HW  = 16 + 3 + 40 + 4 + 4;

  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;
  localparam int CFG_DEV  = 2;
  localparam int A_FREEZE = 'h8;
  localparam int A_ICACHE = 'h10;
  localparam int A_DCACHE = 'h18;
  localparam int A_CCE    = 'h20;
  localparam int A_HIO    = 'h28;
  localparam int UC_BASE  = 'h8000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]    tile_id;
  logic [HW-1:0] cmd_hdr;
  logic [63:0]   cmd_data;
  logic          cmd_v, cmd_ready, cmd_last;
  logic [HW-1:0] resp_hdr;
  logic [63:0]   resp_data;
  logic          resp_v, resp_yumi, resp_last;
  logic          freeze;
  logic [2:0]    icache_mode, dcache_mode;
  logic [0:0]    cce_mode;
  logic [63:0]   hio_mask;
  logic          ucode_v, ucode_w, err;
  logic [IAW-1:0] ucode_addr;
  logic [IW-1:0] ucode_wdata, ucode_rdata;

  bp_me_cfg_responder #(.inst_ram_els_p(ELS), .inst_ram_addr_width_p(IAW), .inst_width_p(IW)) dut
    (.clk_i(clk), .reset_n_i(rst_n), .tile_id_i(tile_id)
    ,.io_cmd_header_i(cmd_hdr), .io_cmd_data_i(cmd_data), .io_cmd_v_i(cmd_v)
    ,.io_cmd_ready_and_o(cmd_ready), .io_cmd_last_i(cmd_last)
    ,.io_resp_header_o(resp_hdr), .io_resp_data_o(resp_data), .io_resp_v_o(resp_v)
    ,.io_resp_yumi_i(resp_yumi), .io_resp_last_o(resp_last)
    ,.freeze_o(freeze), .icache_mode_o(icache_mode), .dcache_mode_o(dcache_mode)
    ,.cce_mode_o(cce_mode), .hio_mask_o(hio_mask)
    ,.ucode_v_o(ucode_v), .ucode_w_o(ucode_w), .ucode_addr_o(ucode_addr)
    ,.ucode_data_o(ucode_wdata), .ucode_data_i(ucode_rdata)
    ,.err_o(err));

  // Ucode RAM seen by the DUT: one-cycle read latency.
  logic [IW-1:0] ram [ELS];
  always @(posedge clk) begin
    if (ucode_v) begin
      if (ucode_w) ram[ucode_addr] <= ucode_wdata;
      else         ucode_rdata     <= ram[ucode_addr];
    end
  end

  // Reference model state.
  logic        m_freeze;
  logic [2:0]  m_icache, m_dcache;
  logic [0:0]  m_cce;
  logic [63:0] m_hio;
  logic        m_err;
  logic [63:0] m_uc [ELS];

  int n_checks = 0;
  int n_errors = 0;
  logic [HW-1:0] last_hdr;
  logic [63:0]   last_data;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dut_regs();
    return 128'({freeze, icache_mode, dcache_mode, cce_mode, hio_mask, err});
  endfunction

  function automatic logic [127:0] model_regs();
    return 128'({m_freeze, m_icache, m_dcache, m_cce, m_hio, m_err});
  endfunction

  task automatic model_reset();
    m_freeze = 1'b1; m_icache = '0; m_dcache = '0; m_cce = '0; m_hio = '0; m_err = 1'b0;
  endtask

  function automatic logic [39:0] mk_addr(input int nonlocal, input int tile, input int dev, input int loc);
    logic [8:0] nl; logic [6:0] t; logic [3:0] d; logic [19:0] l;
    nl = nonlocal[8:0]; t = tile[6:0]; d = dev[3:0]; l = loc[19:0];
    return {nl, t, d, l};
  endfunction

  function automatic int pick_tile();
`ifdef BP_ME_CFG_TILE_CHECK_EN
    return ($urandom_range(0, 7) == 0) ? 0 : 1;
`else
    return int'($urandom_range(0, 127));
`endif
  endfunction

  // Applies one command to the model; returns response data, strobe and latency.
  task automatic model_cmd(input logic [3:0] msg, input logic [39:0] addr, input logic [63:0] data,
                           output logic [63:0] rd, output bit uv, output bit uw,
                           output int uidx, output int lat);
    int loc;
    bit hit;
    bit wr;
    loc = int'(addr[19:0]);
    wr  = (msg == UC_WR);
    rd = '0; uv = 0; uw = 0; uidx = 0; lat = 2;
    hit = (msg == UC_RD || msg == UC_WR) && (int'(addr[23:20]) == CFG_DEV) && (addr[39:31] == '0);
`ifdef BP_ME_CFG_TILE_CHECK_EN
    hit = hit && (addr[30:24] == tile_id);
`endif
    if (!hit)                  m_err = 1'b1;
    else if (loc == A_FREEZE) begin if (wr) m_freeze = data[0];      else rd = 64'(m_freeze); end
    else if (loc == A_ICACHE) begin if (wr) m_icache = data[2:0];    else rd = 64'(m_icache); end
    else if (loc == A_DCACHE) begin if (wr) m_dcache = data[2:0];    else rd = 64'(m_dcache); end
    else if (loc == A_CCE)    begin if (wr) m_cce    = data[0:0];    else rd = 64'(m_cce);    end
    else if (loc == A_HIO)    begin if (wr) m_hio    = data;         else rd = m_hio;         end
    else if (loc >= UC_BASE && loc < UC_BASE + 8*ELS) begin
      uv = 1; uw = wr; uidx = (loc - UC_BASE) / 8;
      if (wr) m_uc[uidx] = data;
      else begin rd = m_uc[uidx]; lat = 3; end
    end
    else m_err = 1'b1;
  endtask

  // Issues one command and checks everything up to the first response cycle.
  task automatic issue_cmd(input logic [3:0] msg, input logic [39:0] addr, input logic [63:0] data);
    logic [HW-1:0] h;
    logic [63:0]  erd;
    logic [127:0] pre;
    bit uv, uw;
    int uidx, elat, cyc, waited;
    h = {16'($urandom), 3'($urandom_range(0, 7)), addr, 4'($urandom_range(0, 15)), msg};
    pre = model_regs();
    model_cmd(msg, addr, data, erd, uv, uw, uidx, elat);
    cmd_hdr = h; cmd_data = data; cmd_v = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    check_eq("accept_ready", 128'(cmd_ready), 128'(1));
    @(posedge clk); #1;
    cmd_v = 1'b0; cmd_hdr = HW'({$urandom, $urandom, $urandom}); cmd_data = {$urandom, $urandom};
    check_eq("ucode_v", 128'(ucode_v), 128'(uv));
    if (uv) begin
      check_eq("ucode_w", 128'(ucode_w), 128'(uw));
      check_eq("ucode_addr", 128'(ucode_addr), 128'(uidx));
      if (uw) check_eq("ucode_data", 128'(ucode_wdata), 128'(data));
    end
    check_eq("regs_pre", dut_regs(), pre);
    check_eq("ready_busy", 128'(cmd_ready), 128'(0));
    cyc = 1;
    while (!resp_v && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check_eq("resp_latency", 128'(cyc), 128'(elat));
    check_eq("resp_hdr", 128'(resp_hdr), 128'(h));
    check_eq("resp_data", 128'(resp_data), 128'(erd));
    check_eq("resp_last", 128'(resp_last), 128'(1));
    check_eq("regs_post", dut_regs(), model_regs());
    last_hdr = h; last_data = erd;
  endtask

  // Holds off the response for a few cycles, then consumes it.
  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_v", 128'(resp_v), 128'(1));
      check_eq("hold_hdr", 128'(resp_hdr), 128'(last_hdr));
      check_eq("hold_data", 128'(resp_data), 128'(last_data));
      check_eq("hold_ready", 128'(cmd_ready), 128'(0));
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
    check_eq("resp_dropped", 128'(resp_v), 128'(0));
    check_eq("ready_back", 128'(cmd_ready), 128'(1));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, 128'(cmd_ready), 128'(0));
    check_eq({tag, "_resp_v"}, 128'(resp_v), 128'(0));
    check_eq({tag, "_ucode_v"}, 128'(ucode_v), 128'(0));
    check_eq({tag, "_regs"}, dut_regs(), 128'({1'b1, 3'b0, 3'b0, 1'b0, 64'b0, 1'b0}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] a;
    logic [3:0]  msg;
    int r, loc, dev;
    for (int i = 0; i < ELS; i++) begin ram[i] = '0; m_uc[i] = '0; end
    tile_id = 7'h15;
`ifdef BP_ME_CFG_TILE_CHECK_EN
    tile_id = 7'd1;
`endif
    cmd_hdr = '0; cmd_data = '0; cmd_v = 0; cmd_last = 1; resp_yumi = 0;
    model_reset();

    #12;
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_reset", 128'(cmd_ready), 128'(1));

    // Freeze release, hio mask round trip, ucode round trip at index 5.
    issue_cmd(UC_WR, mk_addr(0, pick_tile(), CFG_DEV, A_FREEZE), 64'h0);
    check_eq("freeze_released", 128'(freeze), 128'(0));
    consume(0);
`ifdef BP_ME_CFG_TILE_CHECK_EN
    issue_cmd(UC_WR, mk_addr(0, 1, CFG_DEV, A_HIO), 64'h1111_1111_0000_0001);
    consume(1);
    issue_cmd(UC_RD, mk_addr(0, 1, CFG_DEV, A_HIO), 64'h0);
    consume(0);
    issue_cmd(UC_WR, mk_addr(0, 1, CFG_DEV, UC_BASE + 8*5), 64'hDEAD_BEEF_0123_4567);
    consume(0);
    issue_cmd(UC_RD, mk_addr(0, 1, CFG_DEV, UC_BASE + 8*5), 64'h0);
    consume(2);
    issue_cmd(UC_WR, mk_addr(0, 0, CFG_DEV, A_FREEZE), 64'h1);
    check_eq("tile_miss_err", 128'(err), 128'(1));
    consume(0);
`else
    issue_cmd(UC_WR, mk_addr(0, 3, CFG_DEV, A_HIO), 64'h1111_1111_0000_0001);
    consume(1);
    issue_cmd(UC_RD, mk_addr(0, 9, CFG_DEV, A_HIO), 64'h0);
    consume(0);
    issue_cmd(UC_WR, mk_addr(0, 0, CFG_DEV, UC_BASE + 8*5), 64'hDEAD_BEEF_0123_4567);
    consume(0);
    issue_cmd(UC_RD, mk_addr(0, 0, CFG_DEV, UC_BASE + 8*5), 64'h0);
    consume(2);
`endif
    issue_cmd(UC_WR, mk_addr(0, int'(tile_id), CFG_DEV, UC_BASE + 8*ELS), 64'h5555);
    check_eq("oob_err", 128'(err), 128'(1));
    consume(0);

    // Randomized traffic mixing hits, ucode accesses and error cases.
    for (int n = 0; n < 150; n++) begin
      r   = int'($urandom_range(0, 15));
      msg = ($urandom_range(0, 1) == 1) ? UC_WR : UC_RD;
      dev = CFG_DEV;
      loc = A_FREEZE;
      case (r)
        0, 1, 2, 3, 4, 5: begin
          case ($urandom_range(0, 4))
            0: loc = A_FREEZE;
            1: loc = A_ICACHE;
            2: loc = A_DCACHE;
            3: loc = A_CCE;
            default: loc = A_HIO;
          endcase
          a = mk_addr(0, pick_tile(), dev, loc);
        end
        6, 7, 8, 9, 10: a = mk_addr(0, pick_tile(), dev, UC_BASE + 8*int'($urandom_range(0, 15)));
        11: begin
          case ($urandom_range(0, 2))
            0: loc = UC_BASE + 8*ELS;
            1: loc = UC_BASE - 8;
            default: loc = UC_BASE + 8*(ELS-1);
          endcase
          a = mk_addr(0, pick_tile(), dev, loc);
        end
        12: begin
          dev = int'($urandom_range(0, 14));
          if (dev >= CFG_DEV) dev++;
          a = mk_addr(0, pick_tile(), dev, A_HIO);
        end
        13: begin
          msg = 4'($urandom_range(4, 15));
          if ($urandom_range(0, 1) == 1) msg = 4'($urandom_range(0, 1));
          a = mk_addr(0, pick_tile(), dev, A_FREEZE);
        end
        14: a = mk_addr(int'($urandom_range(1, 511)), pick_tile(), dev, A_FREEZE);
        default: a = mk_addr(0, pick_tile(), dev, UC_BASE + int'($urandom_range(0, 8*ELS-1)));
      endcase
      issue_cmd(msg, a, {$urandom, $urandom});
      consume(int'($urandom_range(0, 3)));
    end

    // Reset while a response is pending.
    issue_cmd(UC_WR, mk_addr(0, int'(tile_id), CFG_DEV, A_FREEZE), 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("stall_v", 128'(resp_v), 128'(1));
      check_eq("stall_hdr", 128'(resp_hdr), 128'(last_hdr));
      check_eq("stall_ready", 128'(cmd_ready), 128'(0));
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_mid_reset", 128'(cmd_ready), 128'(1));
    check_eq("resp_v_after_mid_reset", 128'(resp_v), 128'(0));
    issue_cmd(UC_RD, mk_addr(0, int'(tile_id), CFG_DEV, A_FREEZE), 64'h0);
    consume(0);
    issue_cmd(UC_RD, mk_addr(0, int'(tile_id), CFG_DEV, UC_BASE + 8*5), 64'h0);
    consume(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
